clock_tick_gen: RTL and testbench
=================================

# clock_tick_gen

Free-running clock divider and tick-enable generator feeding the board's ripple counter and other slow-display logic on the DE1-SoC. Produces the full `divided_clocks` bus from the 50 MHz board clock, plus a single-cycle `tick` enable on each rising edge of a switch-selected divided bit. Two debounced KEY inputs implement run/pause and single-step. Downstream counters run on `clk` and advance on `tick` instead of being clocked from a divided bit.

## Interface
- `WIDTH`, 32: width of `divided_clocks`.
- `DEBOUNCE_CYCLES`, 1000000: cycles a synchronized key must hold a new level before it is accepted (20 ms at 50 MHz); legal range ≥ 1.
- `clk`  in  1  50 MHz board clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; all state clears immediately on assertion.
- `sel`  in  5  index of `divided_clocks` bit used for ticks (from SW[4:0]).
- `run_n`  in  1  raw KEY, low when pressed; each press toggles run/pause.
- `step_n`  in  1  raw KEY, low when pressed; each press issues one tick while paused.
- `divided_clocks`  out  WIDTH  free-running divider; bit i toggles at 25 MHz / 2^i.
- `tick`  out  1  registered one-cycle enable pulse.
- `running`  out  1  high in RUN state.

## Operation
- Divider:
  - `divided_clocks` increments by 1 every cycle; wraps from all-ones to 0 with no special action.
  - Rising edge of bit i occurs every 2^(i+1) cycles.
- Key path (per key):
  - 2-flop synchronizer.
  - Debouncer: accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - Press = accepted level 1→0, one-cycle pulse. Release generates nothing.
- Edge detect:
  - `prev_bit` register holds `divided_clocks[sel]`.
  - `sel_q` register holds `sel`.
  - An edge is `divided_clocks[sel]`=1 & `prev_bit`=0 & `sel`==`sel_q`. A cycle in which `sel` differs from `sel_q` never counts as an edge.
- FSM, states RUN and PAUSE:
  - RUN: edge → `tick`=1 next cycle. Run press → PAUSE. Step press ignored.
  - PAUSE: edges ignored. Step press → `tick`=1 next cycle. Run press → RUN.
  - Run and step presses in the same cycle: run wins, step is dropped.
  - Entering PAUSE in the same cycle as an edge: that edge's tick is still issued (decision uses the current state).
- `running` = (state == RUN).
- `sel` ≥ WIDTH: the index is taken mod WIDTH (width-truncated).

## Timing
- Reset values:
  - `divided_clocks`=0, `tick`=0, `running`=1 (state RUN).
  - Debounced levels=1 (released); synchronizers=1.
  - `prev_bit`=0, `sel_q`=0.
- Tick latency: the counter edge that sets `divided_clocks[sel]` to 1 is cycle N. `tick` is high for exactly cycle N+1.
- Tick spacing:
  - `sel`=k gives exactly 1 tick per 2^(k+1) cycles.
  - `sel`=0 gives a tick every other cycle. `tick` is never high two consecutive cycles.
- Key latency: raw press stable from cycle P gives a press pulse at cycle P+2+DEBOUNCE_CYCLES.
  - The state change or step tick follows on the next cycle.
- Reset mid-operation: any pending tick is lost; divider restarts at 0. First possible tick at `sel`=0 is cycle 2 after deassertion.

## Configuration
- `CLOCK_TICK_GEN_FAST_SIM_EN`:
  - Defined: both debouncers are bypassed. The press pulse is taken from the synchronizer output's 1→0 transition, so key latency is 3 cycles.
  - Not defined: full debounce per DEBOUNCE_CYCLES.
  - Divider, edge detect and FSM are identical in both builds.

## Test plan
- Reset then release, `sel`=0, running → `tick` high on cycles 2,4,6…; `divided_clocks` reads 0,1,2,3… from cycle 0 after reset.
- `sel`=3, run 64 cycles → exactly 4 ticks, 16 cycles apart; none when `sel` changes 3→5 mid-run in the switch cycle.
- DEBOUNCE_CYCLES=4, `run_n` low with 2-cycle bounces then stable 10 cycles → single press, `running` 1→0 at P+7; `tick` stays 0 for 100 cycles.
- While paused, 3 clean `step_n` presses → exactly 3 one-cycle ticks; step press while running → no extra tick.
- `run_n` and `step_n` pressed in the same cycle while paused → `running`=1, no step tick.
- `reset` asserted while `tick`=1 → `tick`, `divided_clocks` 0 immediately (async), `running`=1.

Source files
------------

// File: rtl/clock_tick_gen.sv
// rtl/clock_tick_gen.sv - free-running clock divider with switch-selected tick enable and run/step keys
//
// clock_tick_gen
//   Divides the board clock into a free-running count and emits a one-cycle
//   tick enable on every rising edge of a selected count bit. Two raw push
//   keys are synchronized and debounced: run_n toggles run/pause, step_n
//   issues a single tick while paused. Downstream logic stays on clk and
//   advances on tick.
//
//   Build option: CLOCK_TICK_GEN_FAST_SIM_EN
//     defined   - debouncers bypassed, press taken from synchronizer edge
//     undefined - full debounce over DEBOUNCE_CYCLES
//
//   Ports
//     clk             board clock, all state on rising edge
//     reset           asynchronous active-low reset
//     sel[4:0]        index of divided_clocks bit used for ticks (mod WIDTH)
//     run_n           raw key, low when pressed; press toggles run/pause
//     step_n          raw key, low when pressed; press steps once while paused
//     divided_clocks  free-running divider count
//     tick            registered one-cycle enable pulse
//     running         high while in the RUN state

// Per-key front end: 2-flop synchronizer, debouncer and press pulse.
//   clk, reset  as in the top level
//   key_n       raw key level, low when pressed
//   press       one-cycle pulse on an accepted 1->0 level change
module clock_tick_gen_key #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic [1:0] sync_q;
    logic       key_s;

    // Synchronizer resets to the released level so a key held through reset
    // is seen as a fresh press once it has been stable long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign key_s = sync_q[1];

`ifdef CLOCK_TICK_GEN_FAST_SIM_EN

    logic level_q;

    // No filtering: the accepted level simply follows the synchronizer one
    // cycle late, which keeps the press pulse aligned with a 1-cycle debounce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= key_s;
            press   <= level_q & ~key_s;
        end
    end

`else

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts consecutive cycles in which the synchronized key differs
    // from the accepted level; the level flips on the DEBOUNCE_CYCLES-th such
    // cycle. Agreement for even one cycle restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= key_s;
                    cnt_q   <= '0;
                    // Only the 1->0 change is a press; release is silent.
                    press   <= ~key_s;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

`endif

endmodule

module clock_tick_gen #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       sel,
    input  logic             run_n,
    input  logic             step_n,
    output logic [WIDTH-1:0] divided_clocks,
    output logic             tick,
    output logic             running
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    logic [WIDTH-1:0] div_q;
    logic [31:0]      sel_ext;
    logic [31:0]      sel_mod;
    logic             sel_bit;
    logic             prev_bit_q;
    logic [4:0]       sel_q;
    logic             edge_hit;
    logic             run_press;
    logic             step_press;
    state_t           state_q;
    state_t           state_d;
    logic             tick_d;
    logic             tick_q;

    // Divider: plain wrap-around counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + WIDTH'(1);
        end
    end

    assign divided_clocks = div_q;

    // Selected bit; an out-of-range sel wraps modulo WIDTH. The compare loop
    // avoids an index wider than the bus.
    assign sel_ext = {27'd0, sel};
    assign sel_mod = sel_ext % WIDTH;

    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sel_mod == 32'(i)) begin
                sel_bit = div_q[i];
            end
        end
    end

    // prev_bit tracks the selected bit under the current sel. The sel == sel_q
    // term masks the switch cycle, where prev_bit still reflects the old bit
    // and could otherwise fake a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_bit_q <= 1'b0;
            sel_q      <= 5'd0;
        end else begin
            prev_bit_q <= sel_bit;
            sel_q      <= sel;
        end
    end

    assign edge_hit = sel_bit & ~prev_bit_q & (sel == sel_q);

    clock_tick_gen_key #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_key (
        .clk   (clk),
        .reset (reset),
        .key_n (run_n),
        .press (run_press)
    );

    clock_tick_gen_key #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_key (
        .clk   (clk),
        .reset (reset),
        .key_n (step_n),
        .press (step_press)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // Tick decisions use the current state, so an edge coinciding with the
    // pausing run press still ticks. A run press shadows a same-cycle step.
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                tick_d = edge_hit;
                if (run_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    tick_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign tick    = tick_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_clock_tick_gen.sv
// tb/tb_clock_tick_gen.sv - self-checking bench for clock_tick_gen
`timescale 1ns/1ps

module tb_clock_tick_gen;

    localparam int W  = 16;
    localparam int DB = 4;

    typedef struct {
        logic [4:0] sel;
        int         len;
        int         exp_cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [4:0]   sel = 5'd0;
    logic         run_n = 1'b1;
    logic         step_n = 1'b1;
    logic [W-1:0] divided_clocks;
    logic         tick;
    logic         running;

    int total = 0;
    int bad   = 0;
    int cyc;
    int exp_q[$];
    int run_pat[20] = '{0,0,1,1,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,1};
    vec_t tbl[6];

    clock_tick_gen #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .run_n          (run_n),
        .step_n         (step_n),
        .divided_clocks (divided_clocks),
        .tick           (tick),
        .running        (running)
    );

    always #10 clk = ~clk;

    // Cycle number since reset release; equals the expected divider value.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard consumer: every tick must match the head of the queue.
    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                total++;
                bad++;
                $display("FAIL tick_missing: no tick seen at cycle %0d (now %0d), required 1", exp_q[0], cyc);
                void'(exp_q.pop_front());
            end
            if (tick) begin
                total++;
                if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                    void'(exp_q.pop_front());
                end else begin
                    bad++;
                    $display("FAIL tick_unexpected: tick=1 at cycle %0d, required 0", cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int prev_sel;
        int t0, p, q, r, s, n0, tk, cnt;

        tbl[0] = '{sel: 5'd0,  len: 16, exp_cnt: 8};
        tbl[1] = '{sel: 5'd3,  len: 20, exp_cnt: 1};
        tbl[2] = '{sel: 5'd5,  len: 60, exp_cnt: 0};
        tbl[3] = '{sel: 5'd3,  len: 64, exp_cnt: 4};
        tbl[4] = '{sel: 5'd17, len: 17, exp_cnt: 4};
        tbl[5] = '{sel: 5'd0,  len: 9,  exp_cnt: 4};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_div", divided_clocks, 0);
        chk("reset_tick", tick, 0);
        chk("reset_running", running, 1);
        reset = 1'b1;

        // Table: sel windows, ticks predicted from the counter value
        prev_sel = 0;
        for (int e = 0; e < 6; e++) begin
            int start, k, per;
            start = cyc;
            sel   = tbl[e].sel;
            k     = int'(tbl[e].sel) % W;
            per   = 2 << k;
            for (int n = start; n < start + tbl[e].len; n++) begin
                if (n == start && int'(tbl[e].sel) != prev_sel) continue;
                if (n % per == (1 << k)) exp_q.push_back(n + 1);
            end
            prev_sel = int'(tbl[e].sel);
            cnt = 0;
            for (int i = 0; i < tbl[e].len; i++) begin
                adv();
                if (tick) cnt++;
                chk("div_count", divided_clocks, cyc % 65536);
            end
            chk("window_ticks", cnt, tbl[e].exp_cnt);
        end

        // Bouncy run press while running at sel=0
        t0 = cyc;
        p  = t0 + 10;
        for (int n = t0 + 1; n <= p + 6; n++) begin
            if (n % 2 == 1) exp_q.push_back(n + 1);
        end
        for (int i = 1; i <= 20; i++) begin
            adv();
            run_n = run_pat[i-1][0];
            chk("run_press_running", running, (cyc <= p + 6) ? 1 : 0);
        end

        // Paused: edges ignored
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            adv();
            if (tick) cnt++;
        end
        chk("pause_ticks", cnt, 0);
        chk("pause_running", running, 0);

        // Three clean step presses while paused
        for (int k = 0; k < 3; k++) begin
            q = cyc + 1;
            exp_q.push_back(q + 7);
            for (int i = 1; i <= 16; i++) begin
                adv();
                step_n = (i <= 6) ? 1'b0 : 1'b1;
            end
            chk("step_running", running, 0);
        end

        // Quiet select, then run and step pressed together while paused
        sel = 5'd15;
        r = cyc + 1;
        for (int i = 1; i <= 16; i++) begin
            adv();
            run_n  = (i <= 6) ? 1'b0 : 1'b1;
            step_n = (i <= 6) ? 1'b0 : 1'b1;
            chk("both_press_running", running, (cyc >= r + 7) ? 1 : 0);
        end

        // Step press while running: nothing
        for (int i = 1; i <= 16; i++) begin
            adv();
            step_n = (i <= 6) ? 1'b0 : 1'b1;
        end
        chk("step_in_run_running", running, 1);

        // Async reset while tick is high
        s    = cyc;
        sel  = 5'd0;
        n0   = (s % 2 == 0) ? s + 1 : s + 2;
        tk   = n0 + 1;
        exp_q.push_back(tk);
        for (int i = 0; i < 6 && cyc < tk; i++) adv();
        chk("reach_tick_cycle", cyc, tk);
        #2;
        chk("tick_before_reset", tick, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_tick", tick, 0);
        chk("async_reset_div", divided_clocks, 0);
        chk("async_reset_running", running, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_reset_div", divided_clocks, 0);
        reset = 1'b1;

        // After release: ticks on cycles 2,4,6,8
        for (int n = 1; n <= 7; n += 2) exp_q.push_back(n + 1);
        for (int i = 0; i < 8; i++) begin
            adv();
            chk("post_reset_div", divided_clocks, cyc);
        end
        sel = 5'd15;
        adv();
        adv();
        chk("post_reset_running", running, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
